mem_access_unit: RTL

Parametrised successor to the combinational load/store data controller. Sits between the core's MEM stage and data memory, and drives a byte-enabled memory port, so stores need no read-modify-write. Handles sub-word and misaligned loads and stores, sign or zero extension, and DATA_WIDTH of 32 or 64. Misaligned accesses that cross a word boundary are split into two memory beats, sequenced by an FSM with valid/ready handshakes.

---
 rtl/mem_access_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-enabled load/store sequencer between the MEM stage and data memory.
// Handles sub-word and misaligned loads/stores with sign or zero extension, DATA_WIDTH 32 or 64.
// Optional feature macro MISALIGN_SPLIT_EN: word-crossing accesses become two memory beats;
// without it, any access not aligned to its own size completes with resp_err_o and no beat.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   req_valid_i / req_ready_o         request handshake (ready only in IDLE)
//   req_write_i, req_addr_i           store flag, byte address
//   req_ctrl_i                        [1:0] size (byte/half/word/dword), [2] unsigned load
//   req_wdata_i                       right-justified store data
//   mem_valid_o / mem_ready_i         memory beat handshake (read data valid with ready)
//   mem_we_o, mem_addr_o, mem_be_o    beat direction, word-aligned address, byte enables
//   mem_wdata_o, mem_rdata_i          lane-aligned write data, read data
//   resp_valid_o, resp_err_o          one-cycle completion pulse and error flag
//   resp_rdata_o                      extended load result, 0 for stores and errors
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [2:0]              req_ctrl_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    mem_valid_o,
    input  logic                    mem_ready_i,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    resp_valid_o,
    output logic                    resp_err_o,
    output logic [DATA_WIDTH-1:0]   resp_rdata_o
);
    localparam int WB  = DATA_WIDTH / 8;
    localparam int OW  = $clog2(WB);
    localparam int IW  = $clog2(DATA_WIDTH);
    localparam int SW  = IW + 1;
    localparam int BW2 = 2 * WB;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
`ifdef MISALIGN_SPLIT_EN
        BEAT1 = 2'd2,
`endif
        RESP  = 2'd3
    } state_t;

    state_t state, nxt;

    logic                  write_q, err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            ctrl_q;
    logic [DATA_WIDTH-1:0] wdata_q, asm_q;

    logic                  illegal, bad_req, sgn;
    logic [OW-1:0]         off;
    logic [3:0]            nb;
    logic [OW+2:0]         sh0;
    logic [6:0]            shn;
    logic [IW-1:0]         msb;
    logic [BW2-1:0]        mask;
    logic [ADDR_WIDTH-1:0] base;
    logic [WB-1:0]         be0;
    logic [DATA_WIDTH-1:0] wd0, keep, ext;

    assign illegal = (req_ctrl_i == 3'b111) || (req_write_i && req_ctrl_i[2]) ||
                     (DATA_WIDTH == 32 && (req_ctrl_i[1:0] == 2'b11 || req_ctrl_i == 3'b110));

`ifdef MISALIGN_SPLIT_EN
    assign bad_req = illegal;
`else
    logic [3:0] req_nb;
    assign req_nb  = 4'd1 << req_ctrl_i[1:0];
    assign bad_req = illegal || ((4'(req_addr_i[OW-1:0]) & (req_nb - 4'd1)) != 4'd0);
`endif

    assign off  = addr_q[OW-1:0];
    assign nb   = 4'd1 << ctrl_q[1:0];
    assign sh0  = {off, 3'b000};
    assign base = {addr_q[ADDR_WIDTH-1:OW], {OW{1'b0}}};
    // Byte mask is built double-width so its overflow past the word becomes the second beat's enables.
    assign mask = (BW2'(1) << nb) - BW2'(1);

    // Extension: keep the low nbytes, fill the rest with the sign bit unless unsigned.
    assign shn  = {nb, 3'b000};
    assign keep = ~({DATA_WIDTH{1'b1}} << shn);
    assign msb  = IW'(shn - 7'd1);
    assign sgn  = !ctrl_q[2] && asm_q[msb];
    assign ext  = (asm_q & keep) | ({DATA_WIDTH{sgn}} & ~keep);

`ifdef MISALIGN_SPLIT_EN
    logic [BW2-1:0]          be_full;
    logic [2*DATA_WIDTH-1:0] wd_full;
    logic [SW-1:0]           sh1;
    logic [4:0]              end_b;
    logic                    split;
    logic [WB-1:0]           be1;
    logic [DATA_WIDTH-1:0]   wd1;
    assign be_full = mask << off;
    assign be0     = be_full[WB-1:0];
    assign be1     = be_full[BW2-1:WB];
    assign wd_full = {{DATA_WIDTH{1'b0}}, wdata_q} << sh0;
    assign wd0     = wd_full[DATA_WIDTH-1:0];
    assign wd1     = wd_full[2*DATA_WIDTH-1:DATA_WIDTH];
    assign sh1     = SW'(DATA_WIDTH) - SW'(sh0);
    assign end_b   = 5'(off) + 5'(nb);
    assign split   = end_b > 5'(WB);
`else
    assign be0 = WB'(mask << off);
    assign wd0 = wdata_q << sh0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (req_valid_i) nxt = bad_req ? RESP : BEAT0;
`ifdef MISALIGN_SPLIT_EN
            BEAT0: if (mem_ready_i) nxt = split ? BEAT1 : RESP;
            BEAT1: if (mem_ready_i) nxt = RESP;
`else
            BEAT0: if (mem_ready_i) nxt = RESP;
`endif
            RESP:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            write_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            ctrl_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
        end else begin
            if (state == IDLE && req_valid_i) begin
                write_q <= req_write_i;
                err_q   <= bad_req;
                addr_q  <= req_addr_i;
                ctrl_q  <= req_ctrl_i;
                wdata_q <= req_wdata_i;
            end
            if (state == BEAT0 && mem_ready_i) asm_q <= mem_rdata_i >> sh0;
`ifdef MISALIGN_SPLIT_EN
            if (state == BEAT1 && mem_ready_i) asm_q <= asm_q | (mem_rdata_i << sh1);
`endif
        end
    end

    // Beat outputs depend only on state and latched request, so they hold while memory stalls.
    always_comb begin
        req_ready_o = state == IDLE;
        mem_valid_o = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (state == BEAT0) begin
            mem_valid_o = 1'b1;
            mem_addr_o  = base;
            mem_be_o    = be0;
            mem_wdata_o = wd0;
        end
`ifdef MISALIGN_SPLIT_EN
        if (state == BEAT1) begin
            mem_valid_o = 1'b1;
            mem_addr_o  = base + ADDR_WIDTH'(WB);
            mem_be_o    = be1;
            mem_wdata_o = wd1;
        end
`endif
        mem_we_o     = mem_valid_o && write_q;
        resp_valid_o = state == RESP;
        resp_err_o   = resp_valid_o && err_q;
        resp_rdata_o = (resp_valid_o && !err_q && !write_q) ? ext : '0;
    end
endmodule
